alu_rs_scheduler: RTL and testbench

Reservation-station scheduler that sequences the shared combinational ALU. It buffers up to `RS_SIZE` dispatched ALU/branch instructions and snoops the ALU and LSU bypass buses to capture operands as they are produced. Each cycle it issues at most one operand-complete entry into a registered ALU input stage. It sits between the decoder/dispatch stage and the ALU; the ALU result returns to the ROB and to this block's wakeup port.

---
 rtl/alu_rs_scheduler_pkg.sv | 66 ++++++
 rtl/alu_rs_scheduler_prio_enc.sv | 32 +++
 rtl/alu_rs_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_scheduler_pkg
//  Description : Shared widths, opcode encodings and entry types for the ALU
//                reservation-station scheduler, plus the bypass snoop helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_scheduler_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ADDR_WIDTH       = 32;
    localparam int ROB_WIDTH        = 4;
    localparam int INS_TYPE_WIDTH   = 6;
    localparam int DEF_RS_SIZE      = 8;
    localparam int DEF_RS_IDX_WIDTH = 3;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

    localparam logic [INS_TYPE_WIDTH-1:0] INS_ADD  = 6'd1;
    localparam logic [INS_TYPE_WIDTH-1:0] INS_ADDI = 6'd2;
    localparam logic [INS_TYPE_WIDTH-1:0] INS_BEQ  = 6'd3;

    typedef struct packed {
        logic                  ready;
        logic [DATA_WIDTH-1:0] value;
        logic [ROB_WIDTH-1:0]  tag;
    } operand_t;

    typedef struct packed {
        logic                      valid;
        logic [INS_TYPE_WIDTH-1:0] ins_type;
        logic [DATA_WIDTH-1:0]     imm;
        logic [ADDR_WIDTH-1:0]     pc;
        logic [ROB_WIDTH-1:0]      reorder;
        operand_t                  rs1;
        operand_t                  rs2;
    } rs_entry_t;

    // A waiting operand captures a matching broadcast; the ALU bus wins when
    // both buses carry the same tag.
    function automatic operand_t snoop(
        input operand_t              op,
        input logic                  alu_en,
        input logic [ROB_WIDTH-1:0]  alu_tag,
        input logic [DATA_WIDTH-1:0] alu_val,
        input logic                  lsu_en,
        input logic [ROB_WIDTH-1:0]  lsu_tag,
        input logic [DATA_WIDTH-1:0] lsu_val
    );
        operand_t r;
        r = op;
        if (!op.ready) begin
            if (alu_en && (alu_tag == op.tag)) begin
                r.ready = 1'b1;
                r.value = alu_val;
            end else if (lsu_en && (lsu_tag == op.tag)) begin
                r.ready = 1'b1;
                r.value = lsu_val;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_scheduler_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : rs_prio_enc
//  Description : Lowest-set-bit encoder with a found flag.
//  Ports       : req_i   - request vector
//                idx_o   - index of the lowest set bit (0 when none)
//                found_o - at least one bit of req_i is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_prio_enc #(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic [WIDTH-1:0]     req_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 found_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_WIDTH'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rs_scheduler
//  Description : Reservation station in front of the shared ALU. Buffers
//                dispatched instructions, snoops ALU/LSU bypass buses for
//                operands and issues one ready entry per cycle into a
//                registered ALU input stage.
//  Ports       : clk_in, rst_in (sync, active high), rdy_in (global freeze)
//                dec2rs_*  - dispatch from decoder; rs2dec_full back-pressure
//                alu2rs_*/lsu2rs_* - bypass broadcasts
//                rob2rs_flush - mispredict rollback
//                rs2alu_*  - registered issue to ALU
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE      = DEF_RS_SIZE,
    parameter int RS_IDX_WIDTH = DEF_RS_IDX_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      dec2rs_enable,
    input  logic [INS_TYPE_WIDTH-1:0] dec2rs_ins_type,
    input  logic                      dec2rs_rs1_ready,
    input  logic                      dec2rs_rs2_ready,
    input  logic [DATA_WIDTH-1:0]     dec2rs_rs1_value,
    input  logic [DATA_WIDTH-1:0]     dec2rs_rs2_value,
    input  logic [ROB_WIDTH-1:0]      dec2rs_rs1_tag,
    input  logic [ROB_WIDTH-1:0]      dec2rs_rs2_tag,
    input  logic [DATA_WIDTH-1:0]     dec2rs_imm,
    input  logic [ADDR_WIDTH-1:0]     dec2rs_pc,
    input  logic [ROB_WIDTH-1:0]      dec2rs_reorder,
    output logic                      rs2dec_full,
    input  logic                      alu2rs_bypass_enable,
    input  logic [ROB_WIDTH-1:0]      alu2rs_bypass_reorder,
    input  logic [DATA_WIDTH-1:0]     alu2rs_bypass_value,
    input  logic                      lsu2rs_bypass_enable,
    input  logic [ROB_WIDTH-1:0]      lsu2rs_bypass_reorder,
    input  logic [DATA_WIDTH-1:0]     lsu2rs_bypass_value,
    input  logic                      rob2rs_flush,
    output logic                      rs2alu_enable,
    output logic [DATA_WIDTH-1:0]     rs2alu_rs1,
    output logic [DATA_WIDTH-1:0]     rs2alu_rs2,
    output logic [DATA_WIDTH-1:0]     rs2alu_imm,
    output logic [INS_TYPE_WIDTH-1:0] rs2alu_ins_type,
    output logic [ADDR_WIDTH-1:0]     rs2alu_pc,
    output logic [ROB_WIDTH-1:0]      rs2alu_reorder
);

    rs_entry_t r_ent_q [RS_SIZE];
    rs_entry_t w_ent_d [RS_SIZE];
    rs_entry_t w_new;

    logic                      r_en_q,   w_en_d;
    logic [DATA_WIDTH-1:0]     r_rs1_q,  w_rs1_d;
    logic [DATA_WIDTH-1:0]     r_rs2_q,  w_rs2_d;
    logic [DATA_WIDTH-1:0]     r_imm_q,  w_imm_d;
    logic [INS_TYPE_WIDTH-1:0] r_type_q, w_type_d;
    logic [ADDR_WIDTH-1:0]     r_pc_q,   w_pc_d;
    logic [ROB_WIDTH-1:0]      r_rob_q,  w_rob_d;

    logic [RS_SIZE-1:0]      w_valid_vec;
    logic [RS_SIZE-1:0]      w_ready_vec;
    logic [RS_SIZE-1:0]      w_free_vec;
    logic [RS_IDX_WIDTH-1:0] w_free_idx;
    logic [RS_IDX_WIDTH-1:0] w_sel_idx;
    logic                    w_free_found;
    logic                    w_sel_found;

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_vec
        assign w_valid_vec[i] = r_ent_q[i].valid;
        assign w_ready_vec[i] = r_ent_q[i].valid & r_ent_q[i].rs1.ready & r_ent_q[i].rs2.ready;
    end

    assign w_free_vec  = ~w_valid_vec;
    assign rs2dec_full = &w_valid_vec;

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_IDX_WIDTH)) u_free_enc (
        .req_i   (w_free_vec),
        .idx_o   (w_free_idx),
        .found_o (w_free_found)
    );

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_IDX_WIDTH)) u_sel_enc (
        .req_i   (w_ready_vec),
        .idx_o   (w_sel_idx),
        .found_o (w_sel_found)
    );

    always_comb begin
        w_ent_d  = r_ent_q;
        w_en_d   = r_en_q;
        w_rs1_d  = r_rs1_q;
        w_rs2_d  = r_rs2_q;
        w_imm_d  = r_imm_q;
        w_type_d = r_type_q;
        w_pc_d   = r_pc_q;
        w_rob_d  = r_rob_q;

        w_new.valid    = 1'b1;
        w_new.ins_type = dec2rs_ins_type;
        w_new.imm      = dec2rs_imm;
        w_new.pc       = dec2rs_pc;
        w_new.reorder  = dec2rs_reorder;
        w_new.rs1      = snoop('{dec2rs_rs1_ready, dec2rs_rs1_value, dec2rs_rs1_tag},
                               alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                               lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
        w_new.rs2      = snoop('{dec2rs_rs2_ready, dec2rs_rs2_value, dec2rs_rs2_tag},
                               alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                               lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);

        if (rdy_in) begin
            if (rob2rs_flush) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    w_ent_d[i].valid = 1'b0;
                end
                w_en_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_ent_q[i].valid) begin
                        w_ent_d[i].rs1 = snoop(r_ent_q[i].rs1,
                            alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                            lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
                        w_ent_d[i].rs2 = snoop(r_ent_q[i].rs2,
                            alu2rs_bypass_enable, alu2rs_bypass_reorder, alu2rs_bypass_value,
                            lsu2rs_bypass_enable, lsu2rs_bypass_reorder, lsu2rs_bypass_value);
                    end
                end

                w_en_d = w_sel_found;
                if (w_sel_found) begin
                    w_rs1_d  = r_ent_q[w_sel_idx].rs1.value;
                    w_rs2_d  = r_ent_q[w_sel_idx].rs2.value;
                    w_imm_d  = r_ent_q[w_sel_idx].imm;
                    w_type_d = r_ent_q[w_sel_idx].ins_type;
                    w_pc_d   = r_ent_q[w_sel_idx].pc;
                    w_rob_d  = r_ent_q[w_sel_idx].reorder;
                    w_ent_d[w_sel_idx].valid = 1'b0;
                end

                // The free slot comes from start-of-cycle valid bits, so it can
                // never be the entry issued on this edge.
                if (dec2rs_enable && w_free_found) begin
                    w_ent_d[w_free_idx] = w_new;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_ent_q[i] <= '0;
            end
            r_en_q   <= 1'b0;
            r_rs1_q  <= ZERO_DATA;
            r_rs2_q  <= ZERO_DATA;
            r_imm_q  <= ZERO_DATA;
            r_type_q <= '0;
            r_pc_q   <= ZERO_ADDR;
            r_rob_q  <= '0;
        end else begin
            r_ent_q  <= w_ent_d;
            r_en_q   <= w_en_d;
            r_rs1_q  <= w_rs1_d;
            r_rs2_q  <= w_rs2_d;
            r_imm_q  <= w_imm_d;
            r_type_q <= w_type_d;
            r_pc_q   <= w_pc_d;
            r_rob_q  <= w_rob_d;
        end
    end

    assign rs2alu_enable   = r_en_q;
    assign rs2alu_rs1      = r_rs1_q;
    assign rs2alu_rs2      = r_rs2_q;
    assign rs2alu_imm      = r_imm_q;
    assign rs2alu_ins_type = r_type_q;
    assign rs2alu_pc       = r_pc_q;
    assign rs2alu_reorder  = r_rob_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rs_scheduler
//  Description : Scoreboard bench for alu_rs_scheduler. A queue-and-array
//                reference model predicts each issue; a monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     rs1;
        logic [DATA_WIDTH-1:0]     rs2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [INS_TYPE_WIDTH-1:0] ins_type;
        logic [ADDR_WIDTH-1:0]     pc;
        logic [ROB_WIDTH-1:0]      rob;
    } iss_t;

    logic clk_in, rst_in, rdy_in;
    logic dec2rs_enable, dec2rs_rs1_ready, dec2rs_rs2_ready;
    logic [INS_TYPE_WIDTH-1:0] dec2rs_ins_type;
    logic [DATA_WIDTH-1:0] dec2rs_rs1_value, dec2rs_rs2_value, dec2rs_imm;
    logic [ROB_WIDTH-1:0] dec2rs_rs1_tag, dec2rs_rs2_tag, dec2rs_reorder;
    logic [ADDR_WIDTH-1:0] dec2rs_pc;
    logic rs2dec_full;
    logic alu2rs_bypass_enable, lsu2rs_bypass_enable, rob2rs_flush;
    logic [ROB_WIDTH-1:0] alu2rs_bypass_reorder, lsu2rs_bypass_reorder;
    logic [DATA_WIDTH-1:0] alu2rs_bypass_value, lsu2rs_bypass_value;
    logic rs2alu_enable;
    logic [DATA_WIDTH-1:0] rs2alu_rs1, rs2alu_rs2, rs2alu_imm;
    logic [INS_TYPE_WIDTH-1:0] rs2alu_ins_type;
    logic [ADDR_WIDTH-1:0] rs2alu_pc;
    logic [ROB_WIDTH-1:0] rs2alu_reorder;

    alu_rs_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec2rs_enable(dec2rs_enable), .dec2rs_ins_type(dec2rs_ins_type),
        .dec2rs_rs1_ready(dec2rs_rs1_ready), .dec2rs_rs2_ready(dec2rs_rs2_ready),
        .dec2rs_rs1_value(dec2rs_rs1_value), .dec2rs_rs2_value(dec2rs_rs2_value),
        .dec2rs_rs1_tag(dec2rs_rs1_tag), .dec2rs_rs2_tag(dec2rs_rs2_tag),
        .dec2rs_imm(dec2rs_imm), .dec2rs_pc(dec2rs_pc), .dec2rs_reorder(dec2rs_reorder),
        .rs2dec_full(rs2dec_full),
        .alu2rs_bypass_enable(alu2rs_bypass_enable), .alu2rs_bypass_reorder(alu2rs_bypass_reorder),
        .alu2rs_bypass_value(alu2rs_bypass_value),
        .lsu2rs_bypass_enable(lsu2rs_bypass_enable), .lsu2rs_bypass_reorder(lsu2rs_bypass_reorder),
        .lsu2rs_bypass_value(lsu2rs_bypass_value),
        .rob2rs_flush(rob2rs_flush),
        .rs2alu_enable(rs2alu_enable), .rs2alu_rs1(rs2alu_rs1), .rs2alu_rs2(rs2alu_rs2),
        .rs2alu_imm(rs2alu_imm), .rs2alu_ins_type(rs2alu_ins_type), .rs2alu_pc(rs2alu_pc),
        .rs2alu_reorder(rs2alu_reorder)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_tests = 0;
    int n_fail  = 0;
    iss_t exp_q[$];

    // Reference model: a plain list of 8 slots.
    bit   m_v  [8];
    iss_t m_ins[8];
    bit   m_r1 [8], m_r2[8];
    int   m_t1 [8], m_t2[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) if (m_v[i]) c++;
        return c;
    endfunction

    // Operand value produced this cycle, if any broadcast carries the tag.
    task automatic m_grab(input int tag, inout bit rdy, inout logic [DATA_WIDTH-1:0] val);
        if (rdy) return;
        if (alu2rs_bypass_enable && int'(alu2rs_bypass_reorder) == tag) begin
            rdy = 1; val = alu2rs_bypass_value;
        end else if (lsu2rs_bypass_enable && int'(lsu2rs_bypass_reorder) == tag) begin
            rdy = 1; val = lsu2rs_bypass_value;
        end
    endtask

    task automatic model_step();
        int sel, slot;
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m_v[i] = 0;
            return;
        end
        if (!rdy_in) return;
        if (rob2rs_flush) begin
            for (int i = 0; i < 8; i++) m_v[i] = 0;
            return;
        end
        sel = -1; slot = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_v[i] && m_r1[i] && m_r2[i]) sel = i;
            if (!m_v[i]) slot = i;
        end
        if (sel >= 0) begin
            exp_q.push_back(m_ins[sel]);
            m_v[sel] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_v[i]) begin
                m_grab(m_t1[i], m_r1[i], m_ins[i].rs1);
                m_grab(m_t2[i], m_r2[i], m_ins[i].rs2);
            end
        end
        if (dec2rs_enable && slot >= 0) begin
            m_v[slot] = 1;
            m_ins[slot] = '{rs1: dec2rs_rs1_value, rs2: dec2rs_rs2_value, imm: dec2rs_imm,
                            ins_type: dec2rs_ins_type, pc: dec2rs_pc, rob: dec2rs_reorder};
            m_r1[slot] = dec2rs_rs1_ready; m_t1[slot] = int'(dec2rs_rs1_tag);
            m_r2[slot] = dec2rs_rs2_ready; m_t2[slot] = int'(dec2rs_rs2_tag);
            m_grab(m_t1[slot], m_r1[slot], m_ins[slot].rs1);
            m_grab(m_t2[slot], m_r2[slot], m_ins[slot].rs2);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic set_idle();
        rdy_in = 1; dec2rs_enable = 0; rob2rs_flush = 0;
        dec2rs_ins_type = '0; dec2rs_rs1_ready = 0; dec2rs_rs2_ready = 0;
        dec2rs_rs1_value = '0; dec2rs_rs2_value = '0; dec2rs_rs1_tag = '0; dec2rs_rs2_tag = '0;
        dec2rs_imm = '0; dec2rs_pc = '0; dec2rs_reorder = '0;
        alu2rs_bypass_enable = 0; alu2rs_bypass_reorder = '0; alu2rs_bypass_value = '0;
        lsu2rs_bypass_enable = 0; lsu2rs_bypass_reorder = '0; lsu2rs_bypass_value = '0;
    endtask

    task automatic disp(input logic [5:0] ty, input bit r1, input int v1, input int t1,
                        input bit r2, input int v2, input int t2, input int imm, input int rob);
        dec2rs_enable = 1; dec2rs_ins_type = ty;
        dec2rs_rs1_ready = r1; dec2rs_rs1_value = v1; dec2rs_rs1_tag = t1[ROB_WIDTH-1:0];
        dec2rs_rs2_ready = r2; dec2rs_rs2_value = v2; dec2rs_rs2_tag = t2[ROB_WIDTH-1:0];
        dec2rs_imm = imm; dec2rs_pc = 32'h1000 + rob * 4; dec2rs_reorder = rob[ROB_WIDTH-1:0];
    endtask

    // Monitor: pops one expected issue per active edge that the model scheduled.
    iss_t prev;
    always @(posedge clk_in) begin
        logic rst_e, rdy_e, en_prev;
        iss_t act, e;
        rst_e = rst_in; rdy_e = rdy_in; en_prev = rs2alu_enable;
        #1;
        act = '{rs1: rs2alu_rs1, rs2: rs2alu_rs2, imm: rs2alu_imm, ins_type: rs2alu_ins_type,
                pc: rs2alu_pc, rob: rs2alu_reorder};
        if (!rst_e) begin
            if (rdy_e) begin
                if (rs2alu_enable) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL issue_unexpected: got rob %0d, expected no issue", act.rob);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            n_fail++;
                            $display("FAIL issue_fields: got %h expected %h", act, e);
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    n_tests++; n_fail++;
                    e = exp_q.pop_front();
                    $display("FAIL issue_missing: got enable 0, expected issue of rob %0d", e.rob);
                end
            end else begin
                chk("freeze_enable", 64'(rs2alu_enable), 64'(en_prev));
                chk("freeze_outputs", 64'(act.rob) ^ {act.rs1, act.rs2}, 64'(prev.rob) ^ {prev.rs1, prev.rs2});
            end
            chk("full_flag", 64'(rs2dec_full), 64'(m_count() == 8));
        end
        prev = act;
    end

    initial begin
        set_idle();
        rst_in = 1;
        tick(); tick();
        rst_in = 0;
        chk("rst_enable", 64'(rs2alu_enable), 0);
        chk("rst_data", {rs2alu_rs1, rs2alu_rs2} | 64'(rs2alu_imm), 0);
        chk("rst_ctl", 64'(rs2alu_pc) | 64'(rs2alu_reorder) | 64'(rs2alu_ins_type), 0);
        chk("rst_full", 64'(rs2dec_full), 0);
        alu2rs_bypass_enable = 1; alu2rs_bypass_reorder = 3; alu2rs_bypass_value = 32'hdead;
        tick(); set_idle(); tick();
        chk("rst_bypass_noissue", 64'(rs2alu_enable), 0);

        // Ready dispatch: two-edge latency, single-cycle enable.
        disp(INS_ADD, 1, 5, 0, 1, 7, 0, 0, 3); tick(); set_idle();
        chk("lat_edge1", 64'(rs2alu_enable), 0);
        tick();
        chk("lat_edge2_en", 64'(rs2alu_enable), 1);
        chk("lat_edge2_data", {rs2alu_rs1, rs2alu_rs2}, {32'd5, 32'd7});
        chk("lat_edge2_rob", 64'(rs2alu_reorder), 3);
        tick();
        chk("lat_edge3_en", 64'(rs2alu_enable), 0);

        // Wakeup one edge after dispatch, then same-cycle capture.
        disp(INS_ADDI, 0, 0, 4, 1, 0, 0, 1, 5); tick(); set_idle();
        lsu2rs_bypass_enable = 1; lsu2rs_bypass_reorder = 4; lsu2rs_bypass_value = 32'h10;
        tick(); set_idle();
        chk("wake_not_yet", 64'(rs2alu_enable), 0);
        tick();
        chk("wake_issue", {32'(rs2alu_enable), rs2alu_rs1}, {32'd1, 32'h10});
        tick();
        disp(INS_ADDI, 0, 0, 4, 1, 0, 0, 1, 6);
        lsu2rs_bypass_enable = 1; lsu2rs_bypass_reorder = 4; lsu2rs_bypass_value = 32'h10;
        tick(); set_idle(); tick();
        chk("capture_issue", {32'(rs2alu_enable), rs2alu_rs1}, {32'd1, 32'h10});
        chk("capture_rob", 64'(rs2alu_reorder), 6);
        tick();

        // Full and fixed index priority.
        for (int i = 0; i < 8; i++) begin
            disp(INS_ADD, 0, 0, 9, 1, i, 0, 0, i); tick();
        end
        set_idle();
        chk("full_set", 64'(rs2dec_full), 1);
        disp(INS_ADD, 1, 1, 0, 1, 1, 0, 0, 15); tick(); set_idle();
        alu2rs_bypass_enable = 1; alu2rs_bypass_reorder = 9; alu2rs_bypass_value = 32'h99;
        tick(); set_idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("prio_order", 64'(rs2alu_reorder), 64'(i));
            if (i == 0) chk("full_drop", 64'(rs2dec_full), 0);
        end
        tick();

        // Flush with a concurrent dispatch.
        for (int i = 8; i < 11; i++) begin
            disp(INS_BEQ, 0, 0, 12, 1, 0, 0, 0, i); tick();
        end
        disp(INS_ADD, 1, 2, 0, 1, 3, 0, 0, 11); tick(); set_idle(); tick();
        chk("pre_flush_en", 64'(rs2alu_enable), 1);
        rob2rs_flush = 1;
        disp(INS_ADD, 1, 4, 0, 1, 4, 0, 0, 12); tick(); set_idle();
        chk("flush_en", 64'(rs2alu_enable), 0);
        chk("flush_full", 64'(rs2dec_full), 0);
        alu2rs_bypass_enable = 1; alu2rs_bypass_reorder = 12; tick(); set_idle(); tick(); tick();
        chk("flush_no_issue", 64'(rs2alu_enable), 0);

        // Freeze with enable high and a bypass present.
        disp(INS_ADD, 0, 0, 13, 1, 0, 0, 0, 4); tick();
        disp(INS_ADD, 1, 8, 0, 1, 9, 0, 0, 1); tick();
        disp(INS_ADD, 1, 10, 0, 1, 11, 0, 0, 2); tick(); set_idle();
        rdy_in = 0; alu2rs_bypass_enable = 1; alu2rs_bypass_reorder = 13; alu2rs_bypass_value = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_hold", {32'(rs2alu_enable), 32'(rs2alu_reorder)}, {32'd1, 32'd1});
        end
        set_idle(); tick();
        chk("resume_rob", 64'(rs2alu_reorder), 2);
        alu2rs_bypass_enable = 1; alu2rs_bypass_reorder = 13; alu2rs_bypass_value = 32'h77;
        tick(); set_idle(); tick();
        chk("resume_wake", {32'(rs2alu_reorder), rs2alu_rs1}, {32'd4, 32'h77});

        // Randomized traffic; the model does all the predicting.
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            rdy_in = ($urandom_range(0, 7) != 0);
            rob2rs_flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1 && m_count() < 8)
                disp(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), int'($urandom()),
                     int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom()),
                     int'($urandom_range(0, 15)), int'($urandom()), int'($urandom_range(0, 15)));
            alu2rs_bypass_enable = 1'($urandom_range(0, 1));
            alu2rs_bypass_reorder = 4'($urandom_range(0, 15));
            alu2rs_bypass_value = $urandom();
            lsu2rs_bypass_enable = 1'($urandom_range(0, 1));
            lsu2rs_bypass_reorder = 4'($urandom_range(0, 15));
            lsu2rs_bypass_value = $urandom();
            tick();
        end
        set_idle(); tick(); tick();
        rob2rs_flush = 1; tick(); set_idle(); tick();
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
